register_controller: RTL

Sequencing and arbitration controller for the 4-bit shift/load register. Two requesters submit operations (clear, load, shift-left N, shift-right N). The block grants one requester at a time, round-robin, and drives the register's 3-bit command and 4-bit data inputs cycle by cycle until the operation completes. It keeps a shadow copy of the register contents so that software and benches can read the expected value without a readback path.

---
 rtl/register_ctrl_pkg.sv | 51 +++++
 rtl/rr_arbiter2.sv | 35 +++
 rtl/register_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/register_ctrl_pkg.sv
// Shared encodings for the shift/load register controller: register command
// codes, requester op codes, controller states and the command/shadow helpers.
package register_ctrl_pkg;

    typedef enum logic [2:0] {
        CMD_HOLD  = 3'b000,
        CMD_RESET = 3'b001,
        CMD_LOAD  = 3'b010,
        CMD_SHL   = 3'b011,
        CMD_SHR   = 3'b100
    } cmd_e;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_SHL   = 2'b10,
        OP_SHR   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_INIT = 2'b00,
        ST_IDLE = 2'b01,
        ST_EXEC = 2'b10
    } state_e;

    function automatic cmd_e op_to_cmd(input op_e op);
        cmd_e cmd;
        case (op)
            OP_CLEAR: cmd = CMD_RESET;
            OP_LOAD:  cmd = CMD_LOAD;
            OP_SHL:   cmd = CMD_SHL;
            default:  cmd = CMD_SHR;
        endcase
        return cmd;
    endfunction

    // Mirrors what the register does with one command on its sampling edge.
    function automatic logic [3:0] apply_cmd(input cmd_e cmd, input logic [3:0] value,
                                             input logic [3:0] data);
        logic [3:0] next;
        case (cmd)
            CMD_RESET: next = '0;
            CMD_LOAD:  next = data;
            CMD_SHL:   next = {value[2:0], 1'b0};
            CMD_SHR:   next = {1'b0, value[3:1]};
            default:   next = value;
        endcase
        return next;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; the priority pointer moves only when the
// controller actually accepts a request.
module rr_arbiter2 (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_a_i,
    input  logic req_b_i,
    input  logic accept_i,
    output logic valid_o,
    output logic pick_b_o
);

    logic last_b_q;
    logic last_b_d;

    assign valid_o  = req_a_i | req_b_i;
    // B wins when alone, or on contention when A was granted last.
    assign pick_b_o = req_b_i & (~req_a_i | ~last_b_q);

    always_comb begin
        last_b_d = last_b_q;
        if (accept_i && valid_o) begin
            last_b_d = pick_b_o;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_b_q <= 1'b1;
        end else begin
            last_b_q <= last_b_d;
        end
    end

endmodule

// File: rtl/register_controller.sv
// Arbitrates two requesters and sequences the 4-bit register's command/data
// inputs, keeping a shadow of the expected register contents.
module register_controller
    import register_ctrl_pkg::*;
(
    input  logic       clockController,
    input  logic       resetController,
    input  logic       reqA,
    input  logic [1:0] opA,
    input  logic [1:0] countA,
    input  logic [3:0] dataA,
    input  logic       reqB,
    input  logic [1:0] opB,
    input  logic [1:0] countB,
    input  logic [3:0] dataB,
    output logic       grantA,
    output logic       grantB,
    output logic       doneA,
    output logic       doneB,
    output logic       busy,
    output logic [2:0] comandController,
    output logic [3:0] dataController,
    output logic [3:0] valueShadow
);

    state_e     state_q, state_d;
    cmd_e       cmd_q, cmd_d;
    logic [3:0] data_q, data_d;
    logic [3:0] shadow_q, shadow_d;
    logic [1:0] rem_q, rem_d;
    logic       owner_b_q, owner_b_d;
    logic       grant_a_q, grant_a_d;
    logic       grant_b_q, grant_b_d;
    logic       done_a_q, done_a_d;
    logic       done_b_q, done_b_d;
    logic       busy_q, busy_d;

    logic       arb_valid;
    logic       arb_pick_b;
    logic       accept;
    op_e        sel_op;
    logic [1:0] sel_count;
    logic [3:0] sel_data;

    rr_arbiter2 u_arb (
        .clk_i    (clockController),
        .rst_i    (resetController),
        .req_a_i  (reqA),
        .req_b_i  (reqB),
        .accept_i (accept),
        .valid_o  (arb_valid),
        .pick_b_o (arb_pick_b)
    );

    assign sel_op    = op_e'(arb_pick_b ? opB : opA);
    assign sel_count = arb_pick_b ? countB : countA;
    assign sel_data  = arb_pick_b ? dataB : dataA;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        data_d    = data_q;
        rem_d     = rem_q;
        owner_b_d = owner_b_q;
        grant_a_d = 1'b0;
        grant_b_d = 1'b0;
        done_a_d  = 1'b0;
        done_b_d  = 1'b0;
        accept    = 1'b0;

        case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
                cmd_d   = CMD_HOLD;
            end
            ST_IDLE: begin
                cmd_d = CMD_HOLD;
                if (arb_valid) begin
                    accept    = 1'b1;
                    state_d   = ST_EXEC;
                    owner_b_d = arb_pick_b;
                    grant_a_d = ~arb_pick_b;
                    grant_b_d = arb_pick_b;
                    cmd_d     = op_to_cmd(sel_op);
                    if (sel_op == OP_LOAD) begin
                        data_d = sel_data;
                    end
                    rem_d = (sel_op == OP_SHL || sel_op == OP_SHR) ? sel_count : 2'd0;
                end
            end
            ST_EXEC: begin
                // The command issued on acceptance repeats until rem runs out.
                if (rem_q == 2'd0) begin
                    cmd_d    = CMD_HOLD;
                    state_d  = ST_IDLE;
                    done_a_d = ~owner_b_q;
                    done_b_d = owner_b_q;
                end else begin
                    rem_d = rem_q - 2'd1;
                end
            end
            default: begin
                state_d = ST_INIT;
                cmd_d   = CMD_RESET;
            end
        endcase

        shadow_d = apply_cmd(cmd_q, shadow_q, data_q);
        busy_d   = (state_d != ST_IDLE);
    end

    always_ff @(posedge clockController or posedge resetController) begin
        if (resetController) begin
            state_q   <= ST_INIT;
            cmd_q     <= CMD_RESET;
            data_q    <= '0;
            shadow_q  <= '0;
            rem_q     <= '0;
            owner_b_q <= 1'b0;
            grant_a_q <= 1'b0;
            grant_b_q <= 1'b0;
            done_a_q  <= 1'b0;
            done_b_q  <= 1'b0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            data_q    <= data_d;
            shadow_q  <= shadow_d;
            rem_q     <= rem_d;
            owner_b_q <= owner_b_d;
            grant_a_q <= grant_a_d;
            grant_b_q <= grant_b_d;
            done_a_q  <= done_a_d;
            done_b_q  <= done_b_d;
            busy_q    <= busy_d;
        end
    end

    assign comandController = cmd_q;
    assign dataController   = data_q;
    assign valueShadow      = shadow_q;
    assign grantA           = grant_a_q;
    assign grantB           = grant_b_q;
    assign doneA            = done_a_q;
    assign doneB            = done_b_q;
    assign busy             = busy_q;

endmodule
